// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the LED matrix scanner: matrix geometry, the scan FSM
// state encoding and a small row-advance helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pong_pkg;

  localparam int MATRIX_ROWS = 16;
  localparam int MATRIX_COLS = 16;

  // Address width of a framebuffer row index.
  localparam int ROW_AW = $clog2(MATRIX_ROWS);

  // Bit counter is one bit wider than needed for 0..15 so it can also hold 16.
  localparam int BIT_CW = $clog2(MATRIX_COLS) + 1;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_LOAD     = 4'd1,
    ST_SHIFT_LO = 4'd2,
    ST_SHIFT_HI = 4'd3,
    ST_LATCH    = 4'd4,
    ST_RCLK_LO  = 4'd5,
    ST_RCLK_HI  = 4'd6,
    ST_DISPLAY  = 4'd7,
    ST_PARK     = 4'd8
  } scan_state_e;

  // Next row index; MATRIX_ROWS is a power of two so 15 wraps to 0 naturally.
  function automatic logic [ROW_AW-1:0] next_row(input logic [ROW_AW-1:0] row);
    return row + 1'b1;
  endfunction

endpackage

// File: rtl/matrix_colshift.sv
// -----------------------------------------------------------------------------
// matrix_colshift
// 16-bit parallel-in / serial-out column register. Loads a framebuffer row and
// shifts it out MSB first; zeros are shifted in so the register drains to 0
// after a full row, which keeps the serial data line low between rows.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears the register)
//   load_i   in   capture din_i on this clock (has priority over shift_i)
//   shift_i  in   shift left by one on this clock
//   din_i    in   parallel row data
//   msb_o    out  current MSB, straight from the register
// -----------------------------------------------------------------------------
module matrix_colshift
  import pong_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [MATRIX_COLS-1:0] din_i,
  output logic                   msb_o
);

  logic [MATRIX_COLS-1:0] sr_q;
  logic [MATRIX_COLS-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {sr_q[MATRIX_COLS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[MATRIX_COLS-1];

endmodule

// File: rtl/matrix_scanner.sv
// -----------------------------------------------------------------------------
// matrix_scanner
// Scans a 16x16 LED matrix one row at a time. For each row it fetches the row
// from a framebuffer, shifts the 16 column bits out serially, latches them,
// clocks the row-select shift chain (a single 1 injected on row 0 walks down
// the chain), and then lights the row for 2^SCREENTIMERWIDTH clocks.
//
// Framebuffer fetch protocol: row_addr is presented during FETCH and the
// framebuffer returns row_data one clock later (during LOAD), where it is
// captured. There is no backpressure; the framebuffer must always answer.
//
// Every output is a flop. The strobe flops are loaded from the *next* state so
// that they line up exactly with the state the FSM is in; CSDI is the column
// register's MSB itself.
//
// Ports:
//   clk32mhz     in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   scanning permitted (sampled at end of dwell and in PARK)
//   row_addr     out  framebuffer row being fetched
//   row_data     in   framebuffer row contents, bit 1 = LED on
//   frame_start  out  one-clock pulse when the row-0 fetch begins
//   CSDI/CCLK/LE out  column serial data, shift clock, latch
//   RSDI/RCLK    out  row-select serial data, shift clock
//   OEB          out  matrix output enable, active low
//   dbg_state    out  current FSM state
// -----------------------------------------------------------------------------
module matrix_scanner
  import pong_pkg::*;
#(
  parameter int SCREENTIMERWIDTH = 10
) (
  input  logic                   clk32mhz,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic [ROW_AW-1:0]      row_addr,
  input  logic [MATRIX_COLS-1:0] row_data,
  output logic                   frame_start,
  output logic                   CSDI,
  output logic                   CCLK,
  output logic                   LE,
  output logic                   RSDI,
  output logic                   RCLK,
  output logic                   OEB,
  output scan_state_e            dbg_state
);

  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(MATRIX_COLS - 1);

  scan_state_e                 state_q, state_d;
  logic [ROW_AW-1:0]           row_q, row_d;
  logic [BIT_CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [SCREENTIMERWIDTH-1:0] dwell_q, dwell_d;

  logic frame_start_q, frame_start_d;
  logic cclk_q, cclk_d;
  logic le_q, le_d;
  logic rsdi_q, rsdi_d;
  logic rclk_q, rclk_d;
  logic oeb_q, oeb_d;

  logic col_load;
  logic col_shift;
  logic col_msb;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    bit_cnt_d = bit_cnt_q;
    dwell_d   = dwell_q;
    col_load  = 1'b0;
    col_shift = 1'b0;

    case (state_q)
      ST_PARK: begin
        if (enable) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        col_load  = 1'b1;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT_LO;
      end

      ST_SHIFT_LO: begin
        state_d = ST_SHIFT_HI;
      end

      // The shift happens on the edge leaving SHIFT_HI, so CSDI stays stable
      // across the whole CCLK high phase.
      ST_SHIFT_HI: begin
        col_shift = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end

      ST_LATCH: begin
        state_d = ST_RCLK_LO;
      end

      ST_RCLK_LO: begin
        state_d = ST_RCLK_HI;
      end

      // Preload all-ones so DISPLAY lasts dwell values 2^W-1 down to 0,
      // i.e. exactly 2^W clocks.
      ST_RCLK_HI: begin
        dwell_d = '1;
        state_d = ST_DISPLAY;
      end

      ST_DISPLAY: begin
        if (dwell_q == '0) begin
          row_d   = next_row(row_q);
          state_d = enable ? ST_FETCH : ST_PARK;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_PARK;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output strobes, computed from the next state so the registered copies
  // coincide with the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_start_d = (state_d == ST_FETCH) && (row_d == '0);
    oeb_d         = (state_d != ST_DISPLAY);
    cclk_d        = (state_d == ST_SHIFT_HI);
    le_d          = (state_d == ST_LATCH);
    rclk_d        = (state_d == ST_RCLK_HI);
    rsdi_d        = ((state_d == ST_RCLK_LO) || (state_d == ST_RCLK_HI)) &&
                    (row_q == '0);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk32mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PARK;
      row_q         <= '0;
      bit_cnt_q     <= '0;
      dwell_q       <= '0;
      frame_start_q <= 1'b0;
      oeb_q         <= 1'b1;
      cclk_q        <= 1'b0;
      le_q          <= 1'b0;
      rsdi_q        <= 1'b0;
      rclk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      bit_cnt_q     <= bit_cnt_d;
      dwell_q       <= dwell_d;
      frame_start_q <= frame_start_d;
      oeb_q         <= oeb_d;
      cclk_q        <= cclk_d;
      le_q          <= le_d;
      rsdi_q        <= rsdi_d;
      rclk_q        <= rclk_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Column shift register
  // ---------------------------------------------------------------------------
  matrix_colshift u_colshift (
    .clk     (clk32mhz),
    .rst_n   (reset_n),
    .load_i  (col_load),
    .shift_i (col_shift),
    .din_i   (row_data),
    .msb_o   (col_msb)
  );

  assign row_addr    = row_q;
  assign frame_start = frame_start_q;
  assign CSDI        = col_msb;
  assign CCLK        = cclk_q;
  assign LE          = le_q;
  assign RSDI        = rsdi_q;
  assign RCLK        = rclk_q;
  assign OEB         = oeb_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_matrix_scanner
// Bench for matrix_scanner with SCREENTIMERWIDTH=2 (4-clock dwell, 41-clock
// row, 656-clock frame). The driver programs a framebuffer model and pushes the
// rows it expects to see displayed; a monitor decodes the serial column/row
// protocol and compares each completed row against the front of exp_q.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matrix_scanner;

  localparam int STW          = 2;
  localparam int DWELL        = 1 << STW;
  localparam int ROW_PERIOD   = 37 + DWELL;
  localparam int FRAME_PERIOD = 16 * ROW_PERIOD;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic enable  = 1'b0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [3:0]  row_addr;
  logic [15:0] row_data;
  logic        frame_start, csdi, cclk, le, rsdi, rclk, oeb;
  pong_pkg::scan_state_e dbg_state;

  matrix_scanner #(.SCREENTIMERWIDTH(STW)) dut (
    .clk32mhz    (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .row_addr    (row_addr),
    .row_data    (row_data),
    .frame_start (frame_start),
    .CSDI        (csdi),
    .CCLK        (cclk),
    .LE          (le),
    .RSDI        (rsdi),
    .RCLK        (rclk),
    .OEB         (oeb),
    .dbg_state   (dbg_state)
  );

  // Framebuffer model: synchronous read, data valid one clock after address.
  logic [15:0] mem [16];
  always @(posedge clk) row_data <= mem[row_addr];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] exp_q[$];   // {row[3:0], column word[15:0]}
  int fs_cyc[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic push_row(input int r);
    exp_q.push_back({4'(r), mem[r % 16]});
  endtask

  task automatic wait_q_le(input int lim, input int budget, input string name);
    int n = 0;
    while (exp_q.size() > lim && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size() <= lim), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oeb"},         32'(oeb),         32'd1);
    check({tag, "_csdi"},        32'(csdi),        32'd0);
    check({tag, "_cclk"},        32'(cclk),        32'd0);
    check({tag, "_le"},          32'(le),          32'd0);
    check({tag, "_rsdi"},        32'(rsdi),        32'd0);
    check({tag, "_rclk"},        32'(rclk),        32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_row_addr"},    32'(row_addr),    32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: decode one row from the serial lines, compare at OEB rising.
  // ---------------------------------------------------------------------------
  logic [15:0] mon_word;
  logic [3:0]  mon_row;
  logic        mon_rsdi;
  int          mon_cclk, mon_le, mon_rclk, mon_dwell;
  logic        prev_oeb = 1'b1, prev_cclk = 1'b0, prev_rclk = 1'b0;
  logic [19:0] e;

  task automatic mon_clear();
    mon_word  = '0;
    mon_row   = '0;
    mon_rsdi  = 1'b0;
    mon_cclk  = 0;
    mon_le    = 0;
    mon_rclk  = 0;
    mon_dwell = 0;
  endtask

  initial mon_clear();

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_clear();
      exp_q.delete();
      prev_oeb  = 1'b1;
      prev_cclk = 1'b0;
      prev_rclk = 1'b0;
    end else begin
      if (frame_start) begin
        check("frame_start_row", 32'(row_addr), 32'd0);
        fs_cyc.push_back(cyc);
      end
      if (cclk || le || rclk) check("oeb_while_strobe", 32'(oeb), 32'd1);
      if (cclk && !prev_cclk) begin
        mon_word = {mon_word[14:0], csdi};
        mon_cclk++;
      end
      if (le) begin
        mon_le++;
        mon_row = row_addr;
      end
      if (rclk && !prev_rclk) begin
        mon_rclk++;
        mon_rsdi = rsdi;
      end
      if (!oeb) mon_dwell++;
      if (!prev_oeb && oeb) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_row: row %0d word 0x%0h completed, none expected", mon_row, mon_word);
        end else begin
          e = exp_q.pop_front();
          check("row_index",  32'(mon_row),  32'(e[19:16]));
          check("col_word",   32'(mon_word), 32'(e[15:0]));
          check("cclk_count", 32'(mon_cclk), 32'd16);
          check("le_count",   32'(mon_le),   32'd1);
          check("rclk_count", 32'(mon_rclk), 32'd1);
          check("rsdi",       32'(mon_rsdi), 32'(e[19:16] == 4'd0));
          check("dwell",      32'(mon_dwell), 32'(DWELL));
        end
        mon_clear();
      end
      prev_oeb  = oeb;
      prev_cclk = cclk;
      prev_rclk = rclk;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    int n;

    // Power-on reset.
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    check("por_state_park", 32'(dbg_state), 32'(pong_pkg::ST_PARK));
    @(posedge clk); #1 reset_n = 1'b1;

    // Disabled: stays parked, nothing lit.
    repeat (4) @(negedge clk);
    check("idle_oeb", 32'(oeb), 32'd1);
    check("idle_row", 32'(row_addr), 32'd0);
    check("idle_cclk", 32'(cclk), 32'd0);

    // Free run 17 rows, row 0 carries the known pattern.
    fill_mem();
    mem[0] = 16'hA5C3;
    fs_cyc.delete();
    for (int r = 0; r < 17; r++) push_row(r % 16);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_fetch_frame_start", 32'(frame_start), 32'd1);
    check("first_fetch_row", 32'(row_addr), 32'd0);
    check("first_fetch_oeb", 32'(oeb), 32'd1);
    wait_q_le(1, 17 * ROW_PERIOD + 50, "run17_progress");
    @(posedge clk); #1 enable = 1'b0;
    wait_q_le(0, 2 * ROW_PERIOD, "run17_done");
    check("frame_start_count", 32'(fs_cyc.size()), 32'd2);
    if (fs_cyc.size() >= 2) check("frame_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'(FRAME_PERIOD));
    repeat (3) @(negedge clk);
    check("park_after_run_oeb", 32'(oeb), 32'd1);
    check("park_after_run_row", 32'(row_addr), 32'd1);

    // Drop enable during row 3 shift; row 3 must still finish in full.
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    fill_mem();
    for (int r = 0; r < 4; r++) push_row(r);
    @(posedge clk); #1 enable = 1'b1;
    n = 0;
    while (row_addr != 4'd3 && n < 4 * ROW_PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("reach_row3", 32'(row_addr), 32'd3);
    repeat (8) @(posedge clk);
    #1 enable = 1'b0;
    wait_q_le(0, 2 * ROW_PERIOD, "row3_done");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("park_oeb", 32'(oeb), 32'd1);
      check("park_strobes", 32'({cclk, le, rclk, frame_start}), 32'd0);
      check("park_row", 32'(row_addr), 32'd4);
    end
    mem[4] = 16'($urandom_range(0, 16'hFFFF));
    push_row(4);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) check("refetch_row", 32'(row_addr), 32'd4);
      if (cclk) break;
    end
    check("refetch_to_first_cclk", 32'(n), 32'd4);
    wait_q_le(0, 2 * ROW_PERIOD, "row4_done");
    repeat (2) @(negedge clk);
    check("park_row5", 32'(row_addr), 32'd5);

    // Asynchronous reset mid-DISPLAY.
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    fill_mem();
    mem[0] = 16'hFFFF;
    push_row(0);
    push_row(1);
    @(posedge clk); #1 enable = 1'b1;
    n = 0;
    while (row_addr != 4'd2 && n < 3 * ROW_PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("reach_row2", 32'(row_addr), 32'd2);
    n = 0;
    while (oeb != 1'b0 && n < 2 * ROW_PERIOD) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("pre_reset_display_oeb", 32'(oeb), 32'd0);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("rst_display");
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_rst_frame_start", 32'(frame_start), 32'd1);
    check("after_rst_row", 32'(row_addr), 32'd0);

    // Asynchronous reset mid-SHIFT with CSDI high.
    n = 0;
    while (cclk != 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_shift_cclk", 32'(cclk), 32'd1);
    check("pre_reset_shift_csdi", 32'(csdi), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("rst_shift");
    enable = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("final_park_oeb", 32'(oeb), 32'd1);
    check("final_park_row", 32'(row_addr), 32'd0);
    check("final_park_cclk", 32'(cclk), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case a bounded loop is ever bypassed.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
